// File: rtl/ps2_key_decoder.sv
// PS/2 set-2 scan-code sequencer: folds E0/F0 prefixes into key events and queues them in a FWFT FIFO.
// Optional typematic repeat suppression is built when PS2_REPEAT_FILTER_EN is defined.
module ps2_key_decoder #(
  parameter int FIFO_DEPTH     = 4,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         code_valid,
  input  logic [7:0]                   code,
  input  logic                         evt_ready,
  output logic                         evt_valid,
  output logic [7:0]                   evt_code,
  output logic                         evt_release,
  output logic                         evt_extended,
  output logic [$clog2(FIFO_DEPTH):0]  fifo_count,
  output logic                         overflow
);

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] TMAX    = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [PW:0]   DEPTH_C = (PW+1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, PFX_E0, PFX_F0, PFX_E0F0} state_t;

  state_t          state_reg, state_next;
  logic [TW-1:0]   tmo_reg, tmo_next;
  logic            emit;
  logic            emit_rel;
  logic            emit_ext;
  logic            is_control;
  logic            push;

  // Bytes that belong to keyboard housekeeping (ack, BAT, errors, pause prefix).
  always_comb begin
    case (code)
      8'h00, 8'hAA, 8'hE1, 8'hFA, 8'hFE, 8'hFF: is_control = 1'b1;
      default:                                  is_control = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
      tmo_reg   <= '0;
    end else begin
      state_reg <= state_next;
      tmo_reg   <= tmo_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    tmo_next   = tmo_reg;
    emit       = 1'b0;
    emit_rel   = (state_reg == PFX_F0) || (state_reg == PFX_E0F0);
    emit_ext   = (state_reg == PFX_E0) || (state_reg == PFX_E0F0);
    if (code_valid) begin
      tmo_next = '0;
      if (is_control) begin
        state_next = IDLE;
      end else if (code == 8'hE0) begin
        state_next = PFX_E0;
      end else if (code == 8'hF0) begin
        case (state_reg)
          IDLE:     state_next = PFX_F0;
          PFX_F0:   state_next = PFX_F0;
          PFX_E0:   state_next = PFX_E0F0;
          default:  state_next = PFX_E0F0;
        endcase
      end else begin
        emit       = 1'b1;
        state_next = IDLE;
      end
    end else if (state_reg == IDLE) begin
      tmo_next = '0;
    end else if (tmo_reg == TMAX) begin
      // Stale partial sequence: abandon it silently.
      state_next = IDLE;
      tmo_next   = '0;
    end else begin
      tmo_next = tmo_reg + 1'b1;
    end
  end

`ifdef PS2_REPEAT_FILTER_EN
  logic       held_reg;
  logic [8:0] held_key_reg;
  logic       same_key;

  assign same_key = held_reg && (held_key_reg == {emit_ext, code});
  assign push     = emit && !(!emit_rel && same_key);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      held_reg     <= 1'b0;
      held_key_reg <= '0;
    end else if (emit) begin
      if (!emit_rel) begin
        if (!same_key) begin
          held_reg     <= 1'b1;
          held_key_reg <= {emit_ext, code};
        end
      end else if (same_key) begin
        held_reg <= 1'b0;
      end
    end
  end
`else
  assign push = emit;
`endif

  // Event FIFO: entry layout is {extended, release, code}.
  logic [9:0]    mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr_reg, rd_ptr_reg;
  logic [PW:0]   count_reg, count_next;
  logic          overflow_reg;
  logic          pop;
  logic          full;
  logic          push_ok;
  logic          drop;
  logic [9:0]    head;
  logic [9:0]    entry;

  assign entry   = {emit_ext, emit_rel, code};
  assign pop     = (count_reg != '0) && evt_ready;
  assign full    = (count_reg == DEPTH_C);
  assign push_ok = push && (!full || pop);
  assign drop    = push && full && !pop;

  genvar gi;
  generate
    for (gi = 0; gi < FIFO_DEPTH; gi++) begin : g_slot
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          mem[gi] <= '0;
        end else if (push_ok && (wr_ptr_reg == PW'(gi))) begin
          mem[gi] <= entry;
        end
      end
    end
  endgenerate

  always_comb begin
    count_next = count_reg;
    case ({push_ok, pop})
      2'b10:   count_next = count_reg + 1'b1;
      2'b01:   count_next = count_reg - 1'b1;
      default: count_next = count_reg;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      count_reg    <= '0;
      overflow_reg <= 1'b0;
    end else begin
      if (push_ok) wr_ptr_reg <= (wr_ptr_reg == PW'(FIFO_DEPTH - 1)) ? '0 : wr_ptr_reg + 1'b1;
      if (pop)     rd_ptr_reg <= (rd_ptr_reg == PW'(FIFO_DEPTH - 1)) ? '0 : rd_ptr_reg + 1'b1;
      count_reg <= count_next;
      if (drop) overflow_reg <= 1'b1;
    end
  end

  // Head fields read as zero whenever the FIFO is empty.
  assign head         = mem[rd_ptr_reg];
  assign evt_valid    = (count_reg != '0);
  assign evt_code     = evt_valid ? head[7:0] : 8'h00;
  assign evt_release  = evt_valid ? head[8]   : 1'b0;
  assign evt_extended = evt_valid ? head[9]   : 1'b0;
  assign fifo_count   = count_reg;
  assign overflow     = overflow_reg;

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Directed bench for ps2_key_decoder (FIFO_DEPTH=4, TIMEOUT_CYCLES=16).
module tb_ps2_key_decoder;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       code_valid = 1'b0;
  logic [7:0] code = 8'h00;
  logic       evt_ready = 1'b0;
  logic       evt_valid;
  logic [7:0] evt_code;
  logic       evt_release;
  logic       evt_extended;
  logic [2:0] fifo_count;
  logic       overflow;

  int n_cmp = 0;
  int n_fail = 0;

  ps2_key_decoder #(.FIFO_DEPTH(4), .TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .rst(rst), .code_valid(code_valid), .code(code),
    .evt_ready(evt_ready), .evt_valid(evt_valid), .evt_code(evt_code),
    .evt_release(evt_release), .evt_extended(evt_extended),
    .fifo_count(fifo_count), .overflow(overflow)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    code_valid = 1'b1;
    code       = b;
    @(posedge clk);
    #1;
    code_valid = 1'b0;
    code       = 8'h00;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    #1;
    n_cmp++;
    if ({evt_valid, evt_code, evt_release, evt_extended, fifo_count, overflow} !== 14'h0) begin
      n_fail++;
      $display("FAIL reset_outputs: got v=%b c=%h r=%b e=%b n=%0d o=%b want all 0",
               evt_valid, evt_code, evt_release, evt_extended, fifo_count, overflow);
    end
    tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic test_make_break();
    evt_ready = 1'b1;
    send_byte(8'h1C);
    n_cmp++;
    if ({evt_valid, evt_code, evt_release, evt_extended} !== {1'b1, 8'h1C, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL make_1c: got v=%b c=%h r=%b e=%b want 1 1c 0 0", evt_valid, evt_code, evt_release, evt_extended);
    end
    $display("evt make code=%h rel=%b ext=%b", evt_code, evt_release, evt_extended);
    tick();
    n_cmp++;
    if (evt_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL make_pulse: got valid=%b want 0", evt_valid);
    end
    send_byte(8'hF0);
    n_cmp++;
    if (evt_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL f0_no_event: got valid=%b want 0", evt_valid);
    end
    send_byte(8'h1C);
    n_cmp++;
    if ({evt_valid, evt_code, evt_release, evt_extended} !== {1'b1, 8'h1C, 1'b1, 1'b0}) begin
      n_fail++;
      $display("FAIL break_1c: got v=%b c=%h r=%b e=%b want 1 1c 1 0", evt_valid, evt_code, evt_release, evt_extended);
    end
    $display("evt break code=%h rel=%b ext=%b", evt_code, evt_release, evt_extended);
    tick();
    n_cmp++;
    if (evt_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL break_pulse: got valid=%b want 0", evt_valid);
    end
  endtask

  task automatic test_extended();
    evt_ready = 1'b1;
    send_byte(8'hE0);
    send_byte(8'h75);
    n_cmp++;
    if ({evt_valid, evt_code, evt_release, evt_extended} !== {1'b1, 8'h75, 1'b0, 1'b1}) begin
      n_fail++;
      $display("FAIL ext_make: got v=%b c=%h r=%b e=%b want 1 75 0 1", evt_valid, evt_code, evt_release, evt_extended);
    end
    tick();
    send_byte(8'hE0);
    send_byte(8'hF0);
    send_byte(8'h75);
    n_cmp++;
    if ({evt_valid, evt_code, evt_release, evt_extended} !== {1'b1, 8'h75, 1'b1, 1'b1}) begin
      n_fail++;
      $display("FAIL ext_break: got v=%b c=%h r=%b e=%b want 1 75 1 1", evt_valid, evt_code, evt_release, evt_extended);
    end
    $display("evt ext break code=%h rel=%b ext=%b", evt_code, evt_release, evt_extended);
    tick();
  endtask

  task automatic test_overflow();
    do_reset();
    evt_ready = 1'b0;
    for (int i = 0; i < 5; i++) send_byte(8'h15 + 8'(i));
    n_cmp++;
    if ({fifo_count, overflow} !== {3'd4, 1'b1}) begin
      n_fail++;
      $display("FAIL ovf_full: got count=%0d ovf=%b want 4 1", fifo_count, overflow);
    end
    tick();
    n_cmp++;
    if ({evt_valid, evt_code, evt_release, evt_extended} !== {1'b1, 8'h15, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL ovf_head_hold: got v=%b c=%h want 1 15", evt_valid, evt_code);
    end
    evt_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      n_cmp++;
      if ({evt_valid, evt_code} !== {1'b1, 8'h15 + 8'(i)}) begin
        n_fail++;
        $display("FAIL ovf_drain%0d: got v=%b c=%h want 1 %h", i, evt_valid, evt_code, 8'h15 + 8'(i));
      end
      $display("evt drained code=%h", evt_code);
      tick();
    end
    n_cmp++;
    if ({evt_valid, fifo_count, overflow} !== {1'b0, 3'd0, 1'b1}) begin
      n_fail++;
      $display("FAIL ovf_after: got v=%b count=%0d ovf=%b want 0 0 1", evt_valid, fifo_count, overflow);
    end
    evt_ready = 1'b0;
  endtask

  task automatic test_full_push_pop();
    do_reset();
    evt_ready = 1'b0;
    for (int i = 0; i < 4; i++) send_byte(8'h21 + 8'(i));
    evt_ready = 1'b1;
    send_byte(8'h25);
    n_cmp++;
    if ({fifo_count, overflow, evt_code} !== {3'd4, 1'b0, 8'h22}) begin
      n_fail++;
      $display("FAIL full_pushpop: got count=%0d ovf=%b head=%h want 4 0 22", fifo_count, overflow, evt_code);
    end
    for (int i = 0; i < 4; i++) begin
      n_cmp++;
      if ({evt_valid, evt_code} !== {1'b1, 8'h22 + 8'(i)}) begin
        n_fail++;
        $display("FAIL full_drain%0d: got v=%b c=%h want 1 %h", i, evt_valid, evt_code, 8'h22 + 8'(i));
      end
      $display("evt drained code=%h", evt_code);
      tick();
    end
    evt_ready = 1'b0;
  endtask

  task automatic test_timeout();
    do_reset();
    evt_ready = 1'b1;
    send_byte(8'hE0);
    repeat (10) tick();
    send_byte(8'h75);
    n_cmp++;
    if ({evt_valid, evt_code, evt_release, evt_extended} !== {1'b1, 8'h75, 1'b0, 1'b1}) begin
      n_fail++;
      $display("FAIL tmo_short: got v=%b c=%h r=%b e=%b want 1 75 0 1", evt_valid, evt_code, evt_release, evt_extended);
    end
    tick();
    send_byte(8'hE0);
    repeat (20) tick();
    send_byte(8'h1C);
    n_cmp++;
    if ({evt_valid, evt_code, evt_release, evt_extended} !== {1'b1, 8'h1C, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL tmo_expired: got v=%b c=%h r=%b e=%b want 1 1c 0 0", evt_valid, evt_code, evt_release, evt_extended);
    end
    $display("evt after timeout code=%h ext=%b", evt_code, evt_extended);
    tick();
  endtask

  task automatic test_control();
    do_reset();
    evt_ready = 1'b1;
    send_byte(8'hF0);
    send_byte(8'hAA);
    n_cmp++;
    if (evt_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL ctrl_aa: got valid=%b want 0", evt_valid);
    end
    send_byte(8'h1C);
    n_cmp++;
    if ({evt_valid, evt_code, evt_release, evt_extended} !== {1'b1, 8'h1C, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL ctrl_1c: got v=%b c=%h r=%b e=%b want 1 1c 0 0", evt_valid, evt_code, evt_release, evt_extended);
    end
    tick();
    send_byte(8'hFA);
    send_byte(8'hE0);
    send_byte(8'hFE);
    n_cmp++;
    if (evt_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL ctrl_fe: got valid=%b want 0", evt_valid);
    end
    send_byte(8'h24);
    n_cmp++;
    if ({evt_valid, evt_code, evt_release, evt_extended} !== {1'b1, 8'h24, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL ctrl_24: got v=%b c=%h r=%b e=%b want 1 24 0 0", evt_valid, evt_code, evt_release, evt_extended);
    end
    tick();
    evt_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    do_reset();
    evt_ready = 1'b0;
    send_byte(8'h33);
    send_byte(8'hF0);
    rst = 1'b1;
    #1;
    n_cmp++;
    if ({evt_valid, evt_code, evt_release, evt_extended, fifo_count, overflow} !== 14'h0) begin
      n_fail++;
      $display("FAIL rst_mid: got v=%b c=%h r=%b e=%b n=%0d o=%b want all 0",
               evt_valid, evt_code, evt_release, evt_extended, fifo_count, overflow);
    end
    tick();
    rst = 1'b0;
    tick();
    send_byte(8'h1C);
    n_cmp++;
    if ({evt_valid, evt_code, evt_release, evt_extended, fifo_count} !== {1'b1, 8'h1C, 1'b0, 1'b0, 3'd1}) begin
      n_fail++;
      $display("FAIL rst_mid_after: got v=%b c=%h r=%b e=%b n=%0d want 1 1c 0 0 1",
               evt_valid, evt_code, evt_release, evt_extended, fifo_count);
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    evt_ready = 1'b0;
    send_byte(8'hE0);
    send_byte(8'hF0);
    send_byte(8'h75);
    send_byte(8'h1C);
    n_cmp++;
    if ({fifo_count, evt_code, evt_release, evt_extended} !== {3'd2, 8'h75, 1'b1, 1'b1}) begin
      n_fail++;
      $display("FAIL b2b_head: got n=%0d c=%h r=%b e=%b want 2 75 1 1", fifo_count, evt_code, evt_release, evt_extended);
    end
    evt_ready = 1'b1;
    tick();
    n_cmp++;
    if ({evt_valid, evt_code, evt_release, evt_extended} !== {1'b1, 8'h1C, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL b2b_second: got v=%b c=%h r=%b e=%b want 1 1c 0 0", evt_valid, evt_code, evt_release, evt_extended);
    end
    tick();
    evt_ready = 1'b0;
  endtask

  task automatic test_repeat();
    logic [8:0] exp_q[$];
`ifdef PS2_REPEAT_FILTER_EN
    exp_q = '{9'h01C, 9'h11C};
`else
    exp_q = '{9'h01C, 9'h01C, 9'h01C, 9'h11C};
`endif
    do_reset();
    evt_ready = 1'b0;
    send_byte(8'h1C);
    send_byte(8'h1C);
    send_byte(8'h1C);
    send_byte(8'hF0);
    send_byte(8'h1C);
    n_cmp++;
    if (fifo_count !== 3'(exp_q.size())) begin
      n_fail++;
      $display("FAIL rpt_count: got %0d want %0d", fifo_count, exp_q.size());
    end
    evt_ready = 1'b1;
    for (int i = 0; i < exp_q.size(); i++) begin
      n_cmp++;
      if ({evt_valid, evt_release, evt_code} !== {1'b1, exp_q[i]}) begin
        n_fail++;
        $display("FAIL rpt_evt%0d: got v=%b r=%b c=%h want 1 %b %h", i, evt_valid, evt_release, evt_code,
                 exp_q[i][8], exp_q[i][7:0]);
      end
      $display("evt repeat-seq code=%h rel=%b", evt_code, evt_release);
      tick();
    end
    n_cmp++;
    if (evt_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL rpt_empty: got valid=%b want 0", evt_valid);
    end
    evt_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_make_break();
    test_extended();
    test_overflow();
    test_full_push_pop();
    test_timeout();
    test_control();
    test_reset_mid();
    test_back_to_back();
    test_repeat();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
